// File: rtl/nec_cmd_fifo.sv
// Buffers decoded NEC frames and in-window repeat codes in a small FWFT FIFO with registered head outputs.
// Optional address filter enabled by defining NEC_ADDR_FILTER_EN (adds filter_en_i / filter_addr_i).
module nec_cmd_fifo #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned REPEAT_TIMEOUT = 4800000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_valid_i,
  input  logic [7:0]                  frame_addr_i,
  input  logic [7:0]                  frame_data_i,
  input  logic                        frame_repeat_i,
  output logic                        cmd_valid_o,
  input  logic                        cmd_ready_i,
  output logic [7:0]                  cmd_addr_o,
  output logic [7:0]                  cmd_data_o,
  output logic                        cmd_repeat_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  input  logic                        clr_overflow_i
`ifdef NEC_ADDR_FILTER_EN
  ,
  input  logic                        filter_en_i,
  input  logic [7:0]                  filter_addr_i
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = (REPEAT_TIMEOUT > 1) ? $clog2(REPEAT_TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rpt;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  cmd_t          head_q, head_d;
  cmd_t          push_entry;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    last_addr_q, last_addr_d;
  logic [7:0]    last_data_q, last_data_d;
  logic [TW-1:0] timer_q, timer_d;

  logic addr_match;
  logic frame_ok;
  logic rpt_ok;
  logic push_req;
  logic push;
  logic pop;
  logic full;

  // Frame acceptance: a filtered-out frame leaves the repeat context untouched
  always_comb begin
    addr_match = 1'b1;
`ifdef NEC_ADDR_FILTER_EN
    addr_match = ~filter_en_i | (frame_addr_i == filter_addr_i);
`endif
  end

  // Push/pop decisions, repeat window and FIFO next state
  always_comb begin
    frame_ok    = frame_valid_i & addr_match;
    rpt_ok      = frame_repeat_i & ~frame_valid_i & (timer_q != '0);
    push_req    = frame_ok | rpt_ok;
    full        = (level_q == LW'(DEPTH));
    pop         = valid_q & cmd_ready_i;
    push        = push_req & (~full | pop);

    push_entry      = '0;
    push_entry.addr = frame_ok ? frame_addr_i : last_addr_q;
    push_entry.data = frame_ok ? frame_data_i : last_data_q;
    push_entry.rpt  = ~frame_ok;

    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    timer_d     = timer_q;
    if (frame_ok) begin
      last_addr_d = frame_addr_i;
      last_data_d = frame_data_i;
      timer_d     = TW'(REPEAT_TIMEOUT);
    end else if (rpt_ok) begin
      timer_d     = TW'(REPEAT_TIMEOUT);
    end else if (timer_q != '0) begin
      timer_d     = timer_q - TW'(1);
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    valid_d  = (level_d != '0);
    head_d   = valid_d ? mem_d[rd_ptr_d] : '0;

    // Drop only when full and nothing leaves this cycle; set beats clear
    overflow_d = overflow_q;
    if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end
    if (push_req & full & ~pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
      timer_q     <= '0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      timer_q     <= timer_d;
    end
  end

  assign cmd_valid_o  = valid_q;
  assign cmd_addr_o   = head_q.addr;
  assign cmd_data_o   = head_q.data;
  assign cmd_repeat_o = head_q.rpt;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_nec_cmd_fifo.sv
// Directed self-checking bench for nec_cmd_fifo (DEPTH=4, short repeat timeout).
module tb_nec_cmd_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_valid_i;
  logic [7:0] frame_addr_i;
  logic [7:0] frame_data_i;
  logic       frame_repeat_i;
  logic       cmd_valid_o;
  logic       cmd_ready_i;
  logic [7:0] cmd_addr_o;
  logic [7:0] cmd_data_o;
  logic       cmd_repeat_o;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       clr_overflow_i;
`ifdef NEC_ADDR_FILTER_EN
  logic       filter_en_i;
  logic [7:0] filter_addr_i;
`endif

  int total = 0;
  int bad   = 0;

  nec_cmd_fifo #(.DEPTH(4), .REPEAT_TIMEOUT(100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_valid_i  (frame_valid_i),
    .frame_addr_i   (frame_addr_i),
    .frame_data_i   (frame_data_i),
    .frame_repeat_i (frame_repeat_i),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_addr_o     (cmd_addr_o),
    .cmd_data_o     (cmd_data_o),
    .cmd_repeat_o   (cmd_repeat_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
`ifdef NEC_ADDR_FILTER_EN
    ,
    .filter_en_i    (filter_en_i),
    .filter_addr_i  (filter_addr_i)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d);
    frame_valid_i = 1'b1;
    frame_addr_i  = a;
    frame_data_i  = d;
    step(1);
    frame_valid_i = 1'b0;
  endtask

  task automatic rpt();
    frame_repeat_i = 1'b1;
    step(1);
    frame_repeat_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] a, input logic [7:0] d, input logic r);
    chk({tag, "_valid"}, 16'(cmd_valid_o), 16'h1);
    chk({tag, "_addr"},  16'(cmd_addr_o), 16'(a));
    chk({tag, "_data"},  16'(cmd_data_o), 16'(d));
    chk({tag, "_rpt"},   16'(cmd_repeat_o), 16'(r));
    cmd_ready_i = 1'b1;
    step(1);
    cmd_ready_i = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    frame_valid_i  = 1'b0;
    frame_addr_i   = '0;
    frame_data_i   = '0;
    frame_repeat_i = 1'b0;
    cmd_ready_i    = 1'b0;
    clr_overflow_i = 1'b0;
`ifdef NEC_ADDR_FILTER_EN
    filter_en_i    = 1'b0;
    filter_addr_i  = '0;
`endif
    step(2);
    chk("rst_valid", 16'(cmd_valid_o), 16'h0);
    chk("rst_level", 16'(level_o), 16'h0);
    chk("rst_ovf",   16'(overflow_o), 16'h0);
    chk("rst_head",  {cmd_addr_o, cmd_data_o}, 16'h0);
    chk("rst_rpt",   16'(cmd_repeat_o), 16'h0);
    rst_n = 1'b1;
    step(1);

    // Single frame, one-cycle latency, then pop to empty
    frame(8'h5A, 8'h3C);
    chk("f1_level", 16'(level_o), 16'h1);
    pop_chk("f1", 8'h5A, 8'h3C, 1'b0);
    chk("f1_empty", 16'(cmd_valid_o), 16'h0);
    chk("f1_level0", 16'(level_o), 16'h0);

    // Empty pop has no effect
    cmd_ready_i = 1'b1;
    step(2);
    cmd_ready_i = 1'b0;
    chk("empty_pop_level", 16'(level_o), 16'h0);

    // Repeat window: frame at E0, repeats at E50, E140 (open) and E300 (closed at E240)
    frame(8'h10, 8'h22);
    step(49);
    rpt();
    step(89);
    rpt();
    step(159);
    rpt();
    chk("win_level", 16'(level_o), 16'h3);
    chk("win_ovf",   16'(overflow_o), 16'h0);
    pop_chk("win0", 8'h10, 8'h22, 1'b0);
    pop_chk("win1", 8'h10, 8'h22, 1'b1);
    pop_chk("win2", 8'h10, 8'h22, 1'b1);
    chk("win_empty", 16'(cmd_valid_o), 16'h0);

    // Repeat one cycle after the timer has run out is ignored
    frame(8'h44, 8'h55);
    step(100);
    rpt();
    chk("late_rpt_level", 16'(level_o), 16'h1);
    pop_chk("late", 8'h44, 8'h55, 1'b0);

    // Overflow: five frames into four slots
    for (int i = 1; i <= 5; i++) frame(8'(i), 8'(8'hA0 + i));
    chk("ovf_level", 16'(level_o), 16'h4);
    chk("ovf_flag",  16'(overflow_o), 16'h1);
    for (int i = 1; i <= 4; i++) pop_chk("ovf_drain", 8'(i), 8'(8'hA0 + i), 1'b0);
    chk("ovf_sticky", 16'(overflow_o), 16'h1);
    clr_overflow_i = 1'b1;
    step(1);
    clr_overflow_i = 1'b0;
    chk("ovf_clr", 16'(overflow_o), 16'h0);

    // Full FIFO with push coincident with pop
    for (int i = 1; i <= 4; i++) frame(8'(8'hB0 + i), 8'(i));
    chk("fp_full", 16'(level_o), 16'h4);
    cmd_ready_i = 1'b1;
    frame(8'hB5, 8'h05);
    cmd_ready_i = 1'b0;
    chk("fp_level", 16'(level_o), 16'h4);
    chk("fp_ovf",   16'(overflow_o), 16'h0);
    for (int i = 2; i <= 5; i++) pop_chk("fp_drain", 8'(8'hB0 + i), 8'(i), 1'b0);

    // Frame and repeat together: frame wins
    frame_repeat_i = 1'b1;
    frame(8'hC1, 8'hD1);
    frame_repeat_i = 1'b0;
    chk("both_level", 16'(level_o), 16'h1);
    chk("both_rpt",   16'(cmd_repeat_o), 16'h0);
    chk("both_addr",  16'(cmd_addr_o), 16'h00C1);
    step(1);
    chk("both_level_hold", 16'(level_o), 16'h1);

    // Async reset with entries queued, then repeat after reset is ignored
    frame(8'hC2, 8'hD2);
    frame(8'hC3, 8'hD3);
    chk("pre_rst_level", 16'(level_o), 16'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(cmd_valid_o), 16'h0);
    chk("arst_level", 16'(level_o), 16'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    rpt();
    step(1);
    chk("arst_rpt_valid", 16'(cmd_valid_o), 16'h0);
    chk("arst_rpt_level", 16'(level_o), 16'h0);

`ifdef NEC_ADDR_FILTER_EN
    // Address filter: mismatching frame discarded, repeat refers to last match
    filter_en_i   = 1'b1;
    filter_addr_i = 8'h07;
    frame(8'h07, 8'h11);
    frame(8'h08, 8'h22);
    rpt();
    chk("flt_level", 16'(level_o), 16'h2);
    pop_chk("flt0", 8'h07, 8'h11, 1'b0);
    pop_chk("flt1", 8'h07, 8'h11, 1'b1);
    chk("flt_empty", 16'(cmd_valid_o), 16'h0);
    filter_en_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
